// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory controller.
// Length encodings, FSM state type and length-to-byte-count mapping.
package dmem_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;
    localparam logic [1:0] LEN_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Reserved length maps to 0 bytes; it is always faulted upstream.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        unique case (len)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            LEN_WORD: n = 3'd4;
            default:  n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load extension and store byte enables.
// raw holds bytes addr..addr+3, lowest address in bits [7:0].
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  len,
    input  logic        sign,
    input  logic [31:0] raw,
    output logic [31:0] rdata,
    output logic [3:0]  be
);

    always_comb begin
        rdata = '0;
        be    = 4'b0000;
        unique case (1'b1)
            (len == LEN_BYTE): begin
                rdata = {{24{sign & raw[7]}}, raw[7:0]};
                be    = 4'b0001;
            end
            (len == LEN_HALF): begin
                rdata = {{16{sign & raw[15]}}, raw[15:0]};
                be    = 4'b0011;
            end
            (len == LEN_WORD): begin
                rdata = raw;
                be    = 4'b1111;
            end
            default: begin
                rdata = '0;
                be    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked byte-addressed little-endian data memory.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned HALF/WORD accesses.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_len,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int IW = $clog2(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [1:0]        len_q;
    logic              sign_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [7:0] mem [DEPTH];

    logic              idle;
    logic              accept;
    logic              go;
    logic              a_we;
    logic [1:0]        a_len;
    logic              a_sign;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [IW-1:0]     base;
    logic [ADDR_W:0]   last;
    logic              range_bad;
    logic              mis;
    logic              fault;
    logic [31:0]       raw;
    logic [31:0]       ld_data;
    logic [3:0]        be;

    // With zero latency the access happens on the accepting edge,
    // so it must use the live request rather than the latched copy.
    assign idle    = (state == S_IDLE);
    assign accept  = idle & req_valid;
    assign a_we    = idle ? req_we    : we_q;
    assign a_len   = idle ? req_len   : len_q;
    assign a_sign  = idle ? req_sign  : sign_q;
    assign a_addr  = idle ? req_addr  : addr_q;
    assign a_wdata = idle ? req_wdata : wdata_q;

    assign go = (LATENCY == 0) ? accept
              : (state == S_WAIT && cnt == 4'd0);

    assign base = a_addr[IW-1:0];
    assign last = {1'b0, a_addr}
                + (ADDR_W+1)'(len_bytes(a_len))
                - (ADDR_W+1)'(1);
    assign range_bad = (last >= (ADDR_W+1)'(DEPTH));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (a_len == LEN_HALF && a_addr[0])
              || (a_len == LEN_WORD && a_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign fault = (a_len == LEN_RSVD) | range_bad | mis;

    always_comb begin
        raw = '0;
        for (int i = 0; i < 4; i++) begin
            raw[8*i +: 8] = mem[base + IW'(i)];
        end
    end

    dmem_lane_align u_align (
        .len   (a_len),
        .sign  (a_sign),
        .raw   (raw),
        .rdata (ld_data),
        .be    (be)
    );

    // Byte array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (go && a_we && !fault && rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[base + IW'(i)] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            we_q      <= 1'b0;
            len_q     <= LEN_BYTE;
            sign_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= go;
            rsp_fault <= go & fault;
            rsp_rdata <= (go && !fault && !a_we) ? ld_data : '0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        len_q     <= req_len;
                        sign_q    <= req_sign;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl.
// Instance 0 runs with LATENCY=0, instance 1 with LATENCY=3.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 4096;
    localparam int LAT1  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0]  req_sign;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_fault;
    logic [1:0]  req_len   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(0)) u0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_len   (req_len[0]),
        .req_sign  (req_sign[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_fault (rsp_fault[0])
    );

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_len   (req_len[1]),
        .req_sign  (req_sign[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_fault (rsp_fault[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acyc;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t me;
    bit   mhave;

    logic [7:0] mdl [DEPTH];

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d]) begin
                    mhave = 1'b0;
                    if (d == 0 && q0.size() > 0) begin
                        me = q0.pop_front();
                        mhave = 1'b1;
                    end else if (d == 1 && q1.size() > 0) begin
                        me = q1.pop_front();
                        mhave = 1'b1;
                    end
                    tests++;
                    if (!mhave) begin
                        fails++;
                        $display("FAIL unexpected_rsp dut%0d: rsp_valid=1 required 0", d);
                    end else begin
                        if (rsp_rdata[d] !== me.rdata) begin
                            fails++;
                            $display("FAIL rsp_rdata dut%0d: got %h required %h",
                                     d, rsp_rdata[d], me.rdata);
                        end
                        tests++;
                        if (rsp_fault[d] !== me.fault) begin
                            fails++;
                            $display("FAIL rsp_fault dut%0d: got %b required %b",
                                     d, rsp_fault[d], me.fault);
                        end
                        tests++;
                        if (cyc - me.acyc != me.lat + 1) begin
                            fails++;
                            $display("FAIL rsp_latency dut%0d: got %0d required %0d",
                                     d, cyc - me.acyc, me.lat + 1);
                        end
                    end
                end else begin
                    tests++;
                    if (rsp_rdata[d] !== 32'h0 || rsp_fault[d] !== 1'b0) begin
                        fails++;
                        $display("FAIL idle_zero dut%0d: rdata=%h fault=%b required 0",
                                 d, rsp_rdata[d], rsp_fault[d]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] mload(input int a, input logic [1:0] len,
                                          input logic s);
        logic [31:0] r;
        int n;
        r = '0;
        n = (len == LEN_BYTE) ? 1 : (len == LEN_HALF) ? 2 : 4;
        for (int i = 0; i < n; i++) r[8*i +: 8] = mdl[a + i];
        if (s && r[8*n-1]) for (int i = 8*n; i < 32; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic issue(input int d, input logic we, input logic [1:0] len,
                         input logic sign, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] er,
                         input logic ef, input bit push);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout dut%0d: req_ready=0 required 1", d);
            return;
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_len[d]   = len;
        req_sign[d]  = sign;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        e.rdata = er;
        e.fault = ef;
        e.acyc  = cyc;
        e.lat   = (d == 0) ? 0 : LAT1;
        if (push) begin
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_len[d]   = 2'($urandom_range(0, 3));
        req_sign[d]  = ~sign;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (((d == 0) ? q0.size() : q1.size()) != 0) begin
            fails++;
            $display("FAIL rsp_timeout dut%0d: pending=%0d required 0", d,
                     (d == 0) ? q0.size() : q1.size());
            if (d == 0) q0.delete();
            else q1.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
                rsp_rdata[d] !== 32'h0 || rsp_fault[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state dut%0d: rdy=%b vld=%b rd=%h flt=%b required 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_fault[d]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_word_roundtrip();
        issue(0, 1, LEN_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
        issue(0, 0, LEN_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
        drain(0);
    endtask

    task automatic test_subword();
        issue(0, 0, LEN_BYTE, 0, 32'h13, 32'h0, 32'h000000DE, 0, 1);
        issue(0, 0, LEN_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 1);
        issue(0, 0, LEN_HALF, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 1);
        issue(0, 0, LEN_HALF, 0, 32'h12, 32'h0, 32'h0000DEAD, 0, 1);
        drain(0);
    endtask

    task automatic test_partial_store();
        issue(0, 1, LEN_BYTE, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0, 1);
        issue(0, 0, LEN_WORD, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 1);
        drain(0);
    endtask

    task automatic test_faults();
        logic [31:0] after;
        after = TRAP ? 32'hDEAD55EF : 32'h567855EF;
        issue(0, 1, LEN_WORD, 0, 32'h12, 32'h12345678, 32'h0, TRAP, 1);
        issue(0, 0, LEN_WORD, 0, 32'h10, 32'h0, after, 0, 1);
        issue(0, 1, LEN_RSVD, 0, 32'h40, 32'h0, 32'h0, 1, 1);
        issue(0, 0, LEN_RSVD, 0, 32'h10, 32'h0, 32'h0, 1, 1);
        issue(0, 1, LEN_WORD, 0, DEPTH - 4, 32'hA1B2C3D4, 32'h0, 0, 1);
        issue(0, 0, LEN_WORD, 0, DEPTH - 4, 32'h0, 32'hA1B2C3D4, 0, 1);
        issue(0, 0, LEN_BYTE, 1, DEPTH - 1, 32'h0, 32'hFFFFFFA1, 0, 1);
        issue(0, 0, LEN_HALF, 0, DEPTH - 1, 32'h0, 32'h0, 1, 1);
        issue(0, 0, LEN_WORD, 0, DEPTH - 2, 32'h0, 32'h0, 1, 1);
        issue(0, 0, LEN_WORD, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1);
        drain(0);
    endtask

    task automatic test_random_model();
        logic [31:0] w;
        logic [1:0]  len;
        logic        s;
        int          a;
        int          n;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) mdl[32'h200 + 4*i + b] = w[8*b +: 8];
            issue(0, 1, LEN_WORD, 0, 32'h200 + 4*i, w, 32'h0, 0, 1);
        end
        for (int i = 0; i < 24; i++) begin
            len = 2'($urandom_range(0, 2));
            s   = 1'($urandom_range(0, 1));
            n   = (len == LEN_BYTE) ? 1 : (len == LEN_HALF) ? 2 : 4;
            a   = 32'h200 + $urandom_range(0, 60);
            if (TRAP) a = a & ~(n - 1);
            issue(0, 0, len, s, a, 32'h0, mload(a, len, s), 0, 1);
        end
        drain(0);
    endtask

    task automatic test_back_to_back();
        int   ca;
        int   cb;
        int   low;
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_len[1]   = LEN_WORD;
        req_sign[1]  = 1'b0;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h11111111;
        ca = cyc;
        e.rdata = 32'h0;
        e.fault = 1'b0;
        e.acyc  = ca;
        e.lat   = LAT1;
        q1.push_back(e);
        @(posedge clk);
        #1;
        req_we[1]    = 1'b0;
        req_wdata[1] = 32'h0;
        low = 0;
        n   = 0;
        @(negedge clk);
        while (req_ready[1] !== 1'b1 && n < 20) begin
            low++;
            n++;
            @(negedge clk);
        end
        cb = cyc;
        e.rdata = 32'h11111111;
        e.acyc  = cb;
        q1.push_back(e);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        tests++;
        if (low != LAT1 + 1) begin
            fails++;
            $display("FAIL ready_low_cycles: got %0d required %0d", low, LAT1 + 1);
        end
        tests++;
        if (cb - ca != LAT1 + 2) begin
            fails++;
            $display("FAIL accept_spacing: got %0d required %0d", cb - ca, LAT1 + 2);
        end
        drain(1);
    endtask

    task automatic test_reset_midop();
        issue(1, 1, LEN_WORD, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            fails++;
            $display("FAIL midop_reset: rdy=%b vld=%b required 1 0",
                     req_ready[1], rsp_valid[1]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid[1] !== 1'b0) begin
                fails++;
                $display("FAIL midop_no_rsp: rsp_valid=%b required 0", rsp_valid[1]);
            end
        end
        issue(1, 0, LEN_WORD, 0, 32'h20, 32'h0, 32'h11111111, 0, 1);
        drain(1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_len[d]   = LEN_BYTE;
            req_sign[d]  = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end
        test_reset();
        test_word_roundtrip();
        test_subword();
        test_partial_store();
        test_faults();
        test_random_model();
        test_back_to_back();
        test_reset_midop();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
